// File: rtl/hierarchical_rf_pkg.sv
// hierarchical_rf_pkg
//   Shared constants and types for the two-level register file:
//   data width, top/sub address map, GUID constant, top-level decode
//   target type and the local response record.
package hierarchical_rf_pkg;

   localparam int unsigned DATA_W = 64;

   // Top-level word addresses (address[5:3])
   localparam logic [2:0] ADDR_SUB_LAST = 3'd3;  // 0..3 forwarded to sub_rf
   localparam logic [2:0] ADDR_G2       = 3'd4;
   localparam logic [2:0] ADDR_G3       = 3'd5;

   // sub_rf word addresses (address[4:3])
   localparam logic [1:0] SUB_ADDR_GUID    = 2'd0;
   localparam logic [1:0] SUB_ADDR_NODE_ID = 2'd1;
   localparam logic [1:0] SUB_ADDR_R1      = 2'd2;

   localparam logic [23:0] GUID_VALUE = 24'h12ABCD;

   typedef enum logic [1:0] {
      TGT_SUB,
      TGT_G2,
      TGT_G3,
      TGT_INV
   } top_target_e;

   // Response of a locally decoded access, waiting for its output slot
   typedef struct packed {
      logic              rd;    // valid read: load data into read_data
      logic              inv;   // invalid address
      logic [DATA_W-1:0] data;
   } rsp_t;

   function automatic top_target_e decode_top(input logic [2:0] a);
      top_target_e t;
      if (a <= ADDR_SUB_LAST) begin
         t = TGT_SUB;
      end else if (a == ADDR_G2) begin
         t = TGT_G2;
      end else if (a == ADDR_G3) begin
         t = TGT_G3;
      end else begin
         t = TGT_INV;
      end
      return t;
   endfunction

endpackage

// File: rtl/hierarchical_rf_sub.sv
// sub_rf
//   Child register file on the subRF bus: node GUID (read-only constant),
//   node_id (software r/w, exported) and the four 16-bit r1 fields with
//   hardware update paths. Request is registered to response in 1 cycle.
//   Ports:
//     clk, res_n                      clock, sync active-low reset
//     address[4:3], read_en, write_en bus request
//     write_data / read_data          bus data
//     access_complete, invalid_address bus response
//     info_rf_node_id                 node_id field
//     info_rf_node_guid_next          reserved, ignored
//     info_rf_r1_r1_N_next / _N       hardware value in / field out, N=1..4
//     info_rf_r1_r1_2/3_written       software-write strobes
//     info_rf_r1_r1_4_wen             hardware write enable for r1_4
module sub_rf
   import hierarchical_rf_pkg::*;
(
   input  logic              clk,
   input  logic              res_n,
   input  logic [4:3]        address,
   input  logic              read_en,
   input  logic              write_en,
   input  logic [DATA_W-1:0] write_data,
   output logic [DATA_W-1:0] read_data,
   output logic              access_complete,
   output logic              invalid_address,
   output logic [15:0]       info_rf_node_id,
   input  logic [23:0]       info_rf_node_guid_next,
   input  logic [15:0]       info_rf_r1_r1_1_next,
   input  logic [15:0]       info_rf_r1_r1_2_next,
   input  logic [15:0]       info_rf_r1_r1_3_next,
   input  logic [15:0]       info_rf_r1_r1_4_next,
   output logic [15:0]       info_rf_r1_r1_1,
   output logic [15:0]       info_rf_r1_r1_2,
   output logic [15:0]       info_rf_r1_r1_3,
   output logic [15:0]       info_rf_r1_r1_4,
   output logic              info_rf_r1_r1_2_written,
   output logic              info_rf_r1_r1_3_written,
   input  logic              info_rf_r1_r1_4_wen
);

   logic              unused_guid_next;

   logic [15:0]       node_id_q, node_id_d;
   logic [15:0]       r1_1_q, r1_1_d;
   logic [15:0]       r1_2_q, r1_2_d;
   logic [15:0]       r1_3_q, r1_3_d;
   logic [15:0]       r1_4_q, r1_4_d;
   logic              r1_2_written_q, r1_2_written_d;
   logic              r1_3_written_q, r1_3_written_d;
   logic              ack_q, ack_d;
   logic              inv_q, inv_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;

   logic              req, addr_ok, wr_node_id, wr_r1;
   logic [DATA_W-1:0] rd_mux;

   assign unused_guid_next = ^info_rf_node_guid_next;

   always_comb begin
      req        = read_en | write_en;
      addr_ok    = (address != 2'd3);
      wr_node_id = write_en && (address == SUB_ADDR_NODE_ID);
      wr_r1      = write_en && (address == SUB_ADDR_R1);

      rd_mux = '0;
      case (address)
         SUB_ADDR_GUID:    rd_mux = {40'd0, GUID_VALUE};
         SUB_ADDR_NODE_ID: rd_mux = {48'd0, node_id_q};
         SUB_ADDR_R1:      rd_mux = {r1_4_q, r1_3_q, r1_2_q, r1_1_q};
         default:          rd_mux = '0;
      endcase

      node_id_d = wr_node_id ? write_data[15:0] : node_id_q;

      // Software write wins over the per-cycle hardware load
      r1_1_d = wr_r1 ? write_data[15:0]  : info_rf_r1_r1_1_next;
      r1_2_d = wr_r1 ? write_data[31:16] : info_rf_r1_r1_2_next;
      r1_3_d = wr_r1 ? write_data[47:32] : info_rf_r1_r1_3_next;
      if (wr_r1) begin
         r1_4_d = write_data[63:48];
      end else if (info_rf_r1_r1_4_wen) begin
         r1_4_d = info_rf_r1_r1_4_next;
      end else begin
         r1_4_d = r1_4_q;
      end

      r1_2_written_d = wr_r1;
      r1_3_written_d = wr_r1;

      ack_d   = req;
      inv_d   = req && !addr_ok;
      rdata_d = rdata_q;
      if (req) begin
         if (!addr_ok) begin
            rdata_d = '0;
         end else if (!write_en) begin
            rdata_d = rd_mux;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!res_n) begin
         node_id_q      <= '0;
         r1_1_q         <= '0;
         r1_2_q         <= '0;
         r1_3_q         <= '0;
         r1_4_q         <= '0;
         r1_2_written_q <= 1'b0;
         r1_3_written_q <= 1'b0;
         ack_q          <= 1'b0;
         inv_q          <= 1'b0;
         rdata_q        <= '0;
      end else begin
         node_id_q      <= node_id_d;
         r1_1_q         <= r1_1_d;
         r1_2_q         <= r1_2_d;
         r1_3_q         <= r1_3_d;
         r1_4_q         <= r1_4_d;
         r1_2_written_q <= r1_2_written_d;
         r1_3_written_q <= r1_3_written_d;
         ack_q          <= ack_d;
         inv_q          <= inv_d;
         rdata_q        <= rdata_d;
      end
   end

   assign read_data               = rdata_q;
   assign access_complete         = ack_q;
   assign invalid_address         = inv_q;
   assign info_rf_node_id         = node_id_q;
   assign info_rf_r1_r1_1         = r1_1_q;
   assign info_rf_r1_r1_2         = r1_2_q;
   assign info_rf_r1_r1_3         = r1_3_q;
   assign info_rf_r1_r1_4         = r1_4_q;
   assign info_rf_r1_r1_2_written = r1_2_written_q;
   assign info_rf_r1_r1_3_written = r1_3_written_q;

endmodule

// File: rtl/hierarchical_rf.sv
// hierarchical_rf
//   Top register file: G2 (addr 4) and G3 (addr 5) local 64-bit registers,
//   addresses 0-3 forwarded through a registered bus to sub_rf, 6-7 invalid.
//   Local responses appear 1 cycle after the request, forwarded ones after 3.
//   Ports:
//     clk, res_n                         clock, sync active-low reset
//     address[5:3], read_en, write_en    host request
//     write_data / read_data             host data
//     access_complete, invalid_address   host response
//     subRF_*                            registered child bus
//     G2_r1_f1_next / G3_r2_f1_next      hardware load values
//     G2_r1_f1 / G3_r2_f1                register values
module hierarchical_rf
   import hierarchical_rf_pkg::*;
(
   input  logic              clk,
   input  logic              res_n,
   input  logic [5:3]        address,
   input  logic              read_en,
   input  logic              write_en,
   input  logic [DATA_W-1:0] write_data,
   output logic [DATA_W-1:0] read_data,
   output logic              access_complete,
   output logic              invalid_address,
   output logic [4:3]        subRF_address,
   output logic              subRF_read_en,
   output logic              subRF_write_en,
   output logic [DATA_W-1:0] subRF_write_data,
   input  logic [DATA_W-1:0] subRF_read_data,
   input  logic              subRF_access_complete,
   input  logic              subRF_invalid_address,
   input  logic [DATA_W-1:0] G2_r1_f1_next,
   input  logic [DATA_W-1:0] G3_r2_f1_next,
   output logic [DATA_W-1:0] G2_r1_f1,
   output logic [DATA_W-1:0] G3_r2_f1
);

   logic [DATA_W-1:0] g2_q, g2_d;
   logic [DATA_W-1:0] g3_q, g3_d;
   logic [1:0]        sub_addr_q, sub_addr_d;
   logic              sub_rd_q, sub_rd_d;
   logic              sub_wr_q, sub_wr_d;
   logic [DATA_W-1:0] sub_wdata_q, sub_wdata_d;
   logic              fwd_wr_q, fwd_wr_d;
   rsp_t              lq0_q, lq0_d;
   rsp_t              lq1_q, lq1_d;
   logic [1:0]        lq_cnt_q, lq_cnt_d;
   logic              ack_q, ack_d;
   logic              inv_q, inv_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;

   top_target_e       tgt;
   logic              req, fwd_req, loc_req;
   logic              sub_pend, direct, pop, push, emit_loc;
   logic [1:0]        cnt_after_pop;
   rsp_t              loc_rsp, out_rsp;

   always_comb begin
      req     = read_en | write_en;
      tgt     = decode_top(address);
      fwd_req = req && (tgt == TGT_SUB);
      loc_req = req && (tgt != TGT_SUB);

      // write_en dominates a simultaneous read_en
      loc_rsp.rd   = !write_en && (tgt != TGT_INV);
      loc_rsp.inv  = (tgt == TGT_INV);
      loc_rsp.data = (tgt == TGT_G2) ? g2_q :
                     (tgt == TGT_G3) ? g3_q : '0;

      g2_d = (loc_req && write_en && (tgt == TGT_G2)) ? write_data : G2_r1_f1_next;
      g3_d = (loc_req && write_en && (tgt == TGT_G3)) ? write_data : G3_r2_f1_next;

      sub_rd_d    = fwd_req && !write_en;
      sub_wr_d    = fwd_req && write_en;
      sub_addr_d  = address[4:3];
      sub_wdata_d = fwd_req ? write_data : sub_wdata_q;
      fwd_wr_d    = sub_wr_q;

      // One response slot per cycle, in request order. A forwarded response
      // always owns its slot; a local response may not overtake a forwarded
      // access already issued (sub_pend), so it waits in a 2-deep queue.
      // At most two forwarded accesses are ever ahead, so two entries suffice.
      sub_pend = sub_rd_q | sub_wr_q;
      direct   = 1'b0;
      pop      = 1'b0;
      emit_loc = 1'b0;
      out_rsp  = loc_rsp;
      if (!subRF_access_complete) begin
         if (lq_cnt_q != 2'd0) begin
            emit_loc = 1'b1;
            pop      = 1'b1;
            out_rsp  = lq0_q;
         end else if (loc_req && !sub_pend) begin
            emit_loc = 1'b1;
            direct   = 1'b1;
         end
      end
      push = loc_req && !direct;

      cnt_after_pop = lq_cnt_q - {1'b0, pop};
      lq0_d = lq0_q;
      lq1_d = lq1_q;
      if (pop) begin
         lq0_d = lq1_q;
      end
      if (push) begin
         if (cnt_after_pop == 2'd0) begin
            lq0_d = loc_rsp;
         end else begin
            lq1_d = loc_rsp;
         end
      end
      lq_cnt_d = cnt_after_pop + {1'b0, push};

      ack_d   = 1'b0;
      inv_d   = 1'b0;
      rdata_d = rdata_q;
      if (subRF_access_complete) begin
         ack_d = 1'b1;
         inv_d = subRF_invalid_address;
         if (subRF_invalid_address) begin
            rdata_d = '0;
         end else if (!fwd_wr_q) begin
            rdata_d = subRF_read_data;
         end
      end else if (emit_loc) begin
         ack_d = 1'b1;
         inv_d = out_rsp.inv;
         if (out_rsp.inv) begin
            rdata_d = '0;
         end else if (out_rsp.rd) begin
            rdata_d = out_rsp.data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!res_n) begin
         g2_q        <= '0;
         g3_q        <= '0;
         sub_addr_q  <= '0;
         sub_rd_q    <= 1'b0;
         sub_wr_q    <= 1'b0;
         sub_wdata_q <= '0;
         fwd_wr_q    <= 1'b0;
         lq0_q       <= '0;
         lq1_q       <= '0;
         lq_cnt_q    <= '0;
         ack_q       <= 1'b0;
         inv_q       <= 1'b0;
         rdata_q     <= '0;
      end else begin
         g2_q        <= g2_d;
         g3_q        <= g3_d;
         sub_addr_q  <= sub_addr_d;
         sub_rd_q    <= sub_rd_d;
         sub_wr_q    <= sub_wr_d;
         sub_wdata_q <= sub_wdata_d;
         fwd_wr_q    <= fwd_wr_d;
         lq0_q       <= lq0_d;
         lq1_q       <= lq1_d;
         lq_cnt_q    <= lq_cnt_d;
         ack_q       <= ack_d;
         inv_q       <= inv_d;
         rdata_q     <= rdata_d;
      end
   end

   assign read_data        = rdata_q;
   assign access_complete  = ack_q;
   assign invalid_address  = inv_q;
   assign subRF_address    = sub_addr_q;
   assign subRF_read_en    = sub_rd_q;
   assign subRF_write_en   = sub_wr_q;
   assign subRF_write_data = sub_wdata_q;
   assign G2_r1_f1         = g2_q;
   assign G3_r2_f1         = g3_q;

endmodule

// File: tb/tb_hierarchical_rf.sv
module tb_hierarchical_rf;

   logic        clk;
   logic        res_n;
   logic [5:3]  address;
   logic        read_en, write_en;
   logic [63:0] write_data, read_data;
   logic        access_complete, invalid_address;
   logic [4:3]  sub_address;
   logic        sub_read_en, sub_write_en;
   logic [63:0] sub_write_data, sub_read_data;
   logic        sub_ack, sub_inv;
   logic [63:0] g2_next, g3_next, g2, g3;
   logic [15:0] node_id;
   logic [23:0] guid_next;
   logic [15:0] n1, n2, n3, n4, r1, r2, r3, r4;
   logic        wr2, wr3, r4_wen;

   int n_checks = 0;
   int n_errors = 0;

   localparam logic [63:0] PAT = 64'h555AAA555AAA555A;

   hierarchical_rf u_top (
      .clk                   (clk),
      .res_n                 (res_n),
      .address               (address),
      .read_en               (read_en),
      .write_en              (write_en),
      .write_data            (write_data),
      .read_data             (read_data),
      .access_complete       (access_complete),
      .invalid_address       (invalid_address),
      .subRF_address         (sub_address),
      .subRF_read_en         (sub_read_en),
      .subRF_write_en        (sub_write_en),
      .subRF_write_data      (sub_write_data),
      .subRF_read_data       (sub_read_data),
      .subRF_access_complete (sub_ack),
      .subRF_invalid_address (sub_inv),
      .G2_r1_f1_next         (g2_next),
      .G3_r2_f1_next         (g3_next),
      .G2_r1_f1              (g2),
      .G3_r2_f1              (g3)
   );

   sub_rf u_sub (
      .clk                     (clk),
      .res_n                   (res_n),
      .address                 (sub_address),
      .read_en                 (sub_read_en),
      .write_en                (sub_write_en),
      .write_data              (sub_write_data),
      .read_data               (sub_read_data),
      .access_complete         (sub_ack),
      .invalid_address         (sub_inv),
      .info_rf_node_id         (node_id),
      .info_rf_node_guid_next  (guid_next),
      .info_rf_r1_r1_1_next    (n1),
      .info_rf_r1_r1_2_next    (n2),
      .info_rf_r1_r1_3_next    (n3),
      .info_rf_r1_r1_4_next    (n4),
      .info_rf_r1_r1_1         (r1),
      .info_rf_r1_r1_2         (r2),
      .info_rf_r1_r1_3         (r3),
      .info_rf_r1_r1_4         (r4),
      .info_rf_r1_r1_2_written (wr2),
      .info_rf_r1_r1_3_written (wr3),
      .info_rf_r1_r1_4_wen     (r4_wen)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not reach its end, got running expected finished");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // One-cycle request; returns 1 time unit after the edge that sampled it
   task automatic issue(input logic [2:0] a, input logic rd, input logic wr, input logic [63:0] d);
      address    = a;
      read_en    = rd;
      write_en   = wr;
      write_data = d;
      tick();
      read_en  = 1'b0;
      write_en = 1'b0;
   endtask

   initial begin
      res_n = 1'b0; address = '0; read_en = 0; write_en = 0; write_data = '0;
      g2_next = '0; g3_next = '0; guid_next = 24'hFFFFFF;
      n1 = '0; n2 = '0; n3 = '0; n4 = '0; r4_wen = 1'b0;
      tick(); tick();
      check("rst_ack", access_complete, 0);
      check("rst_inv", invalid_address, 0);
      check("rst_rdata", read_data, 0);
      check("rst_g2", g2, 0);
      check("rst_node_id", node_id, 0);
      check("rst_r1_4", r4, 0);
      check("rst_sub_rd", sub_read_en, 0);
      res_n = 1'b1;
      tick();

      // Forwarded GUID read: 3-cycle latency
      issue(3'd0, 1, 0, '0);
      check("guid_lat1", access_complete, 0);
      tick();
      check("guid_lat2", access_complete, 0);
      tick();
      check("guid_ack", access_complete, 1);
      check("guid_data", read_data, 64'h12ABCD);
      check("guid_inv", invalid_address, 0);
      tick();
      check("guid_strobe", access_complete, 0);
      check("guid_hold", read_data, 64'h12ABCD);

      // node_id write then readback
      issue(3'd1, 0, 1, PAT);
      tick();
      check("node_id_hw", node_id, 16'h555A);
      tick();
      check("node_wr_ack", access_complete, 1);
      check("node_wr_hold", read_data, 64'h12ABCD);
      issue(3'd1, 1, 0, '0);
      tick(); tick();
      check("node_rd", read_data, 64'h555A);

      // r1 write held for 3 cycles
      address = 3'd2; write_en = 1'b1; write_data = PAT;
      tick(); tick();
      check("r1_1_wr", r1, 16'h555A);
      check("r1_2_wr", r2, 16'h5AAA);
      check("r1_3_wr", r3, 16'hAA55);
      check("r1_4_wr", r4, 16'h555A);
      check("r1_2_written", wr2, 1);
      check("r1_3_written", wr3, 1);
      tick();
      write_en = 1'b0;
      tick();
      check("r1_1_last_wr", r1, 16'h555A);
      tick();
      check("r1_1_hw", r1, 0);
      check("r1_2_hw", r2, 0);
      check("r1_3_hw", r3, 0);
      check("r1_4_kept", r4, 16'h555A);
      check("r1_2_written_off", wr2, 0);
      check("r1_wr3_ack", access_complete, 1);
      tick();
      check("r1_ack_done", access_complete, 0);
      r4_wen = 1'b1;
      tick();
      check("r1_4_wen", r4, 0);
      r4_wen = 1'b0;
      n1 = 16'h1111; n2 = 16'h2222; n3 = 16'h3333; n4 = 16'h4444;
      tick();
      check("r1_4_no_wen", r4, 0);
      issue(3'd2, 1, 0, '0);
      tick(); tick();
      check("r1_rd", read_data, 64'h0000_3333_2222_1111);

      // sub invalid address and read-only GUID
      issue(3'd3, 1, 0, '0);
      tick(); tick();
      check("sub3_rd_ack", access_complete, 1);
      check("sub3_rd_inv", invalid_address, 1);
      check("sub3_rd_data", read_data, 0);
      issue(3'd3, 0, 1, PAT);
      tick(); tick();
      check("sub3_wr_inv", invalid_address, 1);
      check("sub3_wr_node", node_id, 16'h555A);
      issue(3'd0, 0, 1, PAT);
      tick(); tick();
      check("guid_wr_ack", access_complete, 1);
      check("guid_wr_inv", invalid_address, 0);
      issue(3'd0, 1, 0, '0);
      tick(); tick();
      check("guid_ro", read_data, 64'h12ABCD);

      // Local registers
      issue(3'd4, 0, 1, 64'hDEAD);
      check("g2_wr", g2, 64'hDEAD);
      check("g2_wr_ack", access_complete, 1);
      check("g2_wr_inv", invalid_address, 0);
      tick();
      check("g2_hw", g2, 0);
      check("g2_ack_off", access_complete, 0);
      issue(3'd5, 1, 1, 64'hBEEF);
      check("g3_wr", g3, 64'hBEEF);
      g2_next = 64'hCAFE;
      tick();
      issue(3'd4, 1, 0, '0);
      check("g2_rd", read_data, 64'hCAFE);
      issue(3'd6, 1, 0, '0);
      check("a6_ack", access_complete, 1);
      check("a6_inv", invalid_address, 1);
      check("a6_data", read_data, 0);
      issue(3'd7, 0, 1, PAT);
      check("a7_inv", invalid_address, 1);

      // Forwarded read followed immediately by a local read: order kept
      address = 3'd0; read_en = 1'b1;
      tick();
      address = 3'd4;
      tick();
      read_en = 1'b0;
      check("pipe_wait", access_complete, 0);
      tick();
      check("pipe_fwd_ack", access_complete, 1);
      check("pipe_fwd_data", read_data, 64'h12ABCD);
      tick();
      check("pipe_loc_ack", access_complete, 1);
      check("pipe_loc_data", read_data, 64'hCAFE);
      tick();
      check("pipe_done", access_complete, 0);

      // Reset during a forwarded access
      g2_next = '0;
      issue(3'd0, 1, 0, '0);
      res_n = 1'b0;
      tick();
      check("mid_rst_ack", access_complete, 0);
      check("mid_rst_sub_rd", sub_read_en, 0);
      tick();
      check("mid_rst_ack2", access_complete, 0);
      check("mid_rst_node", node_id, 0);
      check("mid_rst_r1_1", r1, 0);
      check("mid_rst_g2", g2, 0);
      check("mid_rst_rdata", read_data, 0);
      res_n = 1'b1;
      tick();
      check("post_rst_ack1", access_complete, 0);
      tick();
      check("post_rst_ack2", access_complete, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
